// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-segment 7-segment display.
// Holds a double-buffered BCD value that only changes at frame boundaries, so a frame never tears.
module seg7_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int DIV          = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    input  logic                  lz_en,
    input  logic                  enable,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   dig_en,
    output logic                  pending,
    output logic                  frame_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] disp_val;
    logic [N_DIGITS-1:0]   disp_dp;
    logic [4*N_DIGITS-1:0] pend_val;
    logic [N_DIGITS-1:0]   pend_dp;

    logic                  slot_end;
    logic                  boundary;
    logic                  blank_phase;
    logic                  suppress;
    logic [3:0]            cur_digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h7E;
            4'd1:    code = 7'h30;
            4'd2:    code = 7'h6D;
            4'd3:    code = 7'h79;
            4'd4:    code = 7'h33;
            4'd5:    code = 7'h5B;
            4'd6:    code = 7'h5F;
            4'd7:    code = 7'h70;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h7B;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

    // True when every digit from position 'from' up to the most significant one is zero.
    function automatic logic upper_all_zero(input logic [4*N_DIGITS-1:0] v,
                                            input logic [IDX_W-1:0]      from);
        logic z;
        z = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if ((k >= int'(from)) && (v[4*k +: 4] != 4'd0)) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

    assign slot_end    = (cnt == CNT_LAST);
    assign boundary    = slot_end && (idx == IDX_LAST);
    assign blank_phase = (cnt < CNT_BLANK);
    assign cur_digit   = disp_val[4*idx +: 4];
    assign suppress    = lz_en && (idx != '0) && upper_all_zero(disp_val, idx);

    // Free-running slot prescaler and digit index; keeps running even when the display is off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load in the boundary cycle lands in the pending buffer after the commit has already
    // taken the old contents, so the new value waits a full frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val <= '0;
            pend_dp  <= '0;
            disp_val <= '0;
            disp_dp  <= '0;
            pending  <= 1'b0;
        end else begin
            if (load) begin
                pend_val <= value_in;
                pend_dp  <= dp_in;
            end
            if (boundary && pending) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            if (load) begin
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    // Registered pin drivers: dark during the anti-ghosting window or when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= '0;
            dp         <= 1'b0;
            dig_en     <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (!enable || blank_phase) begin
                seg    <= '0;
                dp     <= 1'b0;
                dig_en <= '0;
            end else begin
                seg    <= suppress ? 7'h00 : decode(cur_digit);
                dp     <= disp_dp[idx];
                dig_en <= N_DIGITS'(1) << idx;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed scoreboard bench for seg7_scan_ctrl with N_DIGITS=4, DIV=4, BLANK_CYCLES=1.
// Each frame's expected pin values are queued up front and popped one per cycle.
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int BLANK = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  value_in;
    logic [3:0]   dp_in;
    logic         load;
    logic         lz_en;
    logic         enable;
    logic [6:0]   seg;
    logic         dp;
    logic [3:0]   dig_en;
    logic         pending;
    logic         frame_tick;

    int checks = 0;
    int passed = 0;
    logic [13:0] exp_q[$];

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .N_DIGITS    (N),
        .DIV         (DIV),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value_in  (value_in),
        .dp_in     (dp_in),
        .load      (load),
        .lz_en     (lz_en),
        .enable    (enable),
        .seg       (seg),
        .dp        (dp),
        .dig_en    (dig_en),
        .pending   (pending),
        .frame_tick(frame_tick)
    );

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'h7E;
            4'd1:    c = 7'h30;
            4'd2:    c = 7'h6D;
            4'd3:    c = 7'h79;
            4'd4:    c = 7'h33;
            4'd5:    c = 7'h5B;
            4'd6:    c = 7'h5F;
            4'd7:    c = 7'h70;
            4'd8:    c = 7'h7F;
            4'd9:    c = 7'h7B;
            default: c = 7'h00;
        endcase
        return c;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k, input logic lz);
        logic zeros;
        zeros = 1'b1;
        for (int j = k; j < N; j++) begin
            if (v[4*j +: 4] != 4'd0) zeros = 1'b0;
        end
        if (lz && (k > 0) && zeros) return 7'h00;
        return seg_code(v[4*k +: 4]);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] d,
                                 input logic en, input logic lz);
        load     = ld;
        value_in = v;
        dp_in    = d;
        enable   = en;
        lz_en    = lz;
    endtask

    // Called at the negedge of the cycle that follows a boundary (offset 0). Offsets 1..16
    // cover one full frame; offset 16 is the next frame_tick cycle.
    task automatic runFrame(input string name, input logic [15:0] v, input logic [3:0] dv,
                            input logic lz, input logic pend_start,
                            input int ld_a, input logic [15:0] va, input logic [3:0] da,
                            input int ld_b, input logic [15:0] vb,
                            input int en_from, input int en_to);
        logic        pend;
        logic        en_c;
        logic        vis;
        int          c;
        int          slot;
        logic [3:0]  dig;
        logic [6:0]  sg;
        logic        d1;
        logic [13:0] obs_t;
        logic [13:0] exp_t;
        pend = pend_start;
        for (int o = 1; o <= 16; o++) begin
            c    = o - 1;
            en_c = !((c >= en_from) && (c <= en_to));
            if ((c == ld_a) || (c == ld_b)) pend = 1'b1;
            else if (c == 15) pend = 1'b0;
            slot = c / DIV;
            vis  = en_c && ((c % DIV) >= BLANK);
            dig  = vis ? 4'(1 << slot) : 4'd0;
            sg   = vis ? exp_seg(v, slot, lz) : 7'd0;
            d1   = vis ? dv[slot] : 1'b0;
            exp_q.push_back({(o == 16), pend, dig, sg, d1});
        end
        for (int o = 0; o <= 16; o++) begin
            if (o > 0) begin
                @(negedge clk);
                obs_t = {frame_tick, pending, dig_en, seg, dp};
                exp_t = exp_q.pop_front();
                checkOutput($sformatf("%s o=%0d {tick,pend,dig,seg,dp}", name, o),
                            32'(obs_t), 32'(exp_t));
            end
            applyStimulus((o == ld_a) || (o == ld_b),
                          (o == ld_b) ? vb : va,
                          (o == ld_b) ? 4'd0 : da,
                          !((o >= en_from) && (o <= en_to)), lz);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset seg",        32'(seg),        32'd0);
        checkOutput("reset dp",         32'(dp),         32'd0);
        checkOutput("reset dig_en",     32'(dig_en),     32'd0);
        checkOutput("reset frame_tick", 32'(frame_tick), 32'd0);
        checkOutput("reset pending",    32'(pending),    32'd0);

        $display("[TB] scan after reset, load 0x1234");
        rst_n = 1'b1;
        runFrame("t1_first",  16'h0000, 4'h0,    1'b0, 1'b0, 0,  16'h1234, 4'b0010, -1, 16'h0000, 0, -1);
        runFrame("t1_1234",   16'h1234, 4'b0010, 1'b1, 1'b0, 1,  16'h0056, 4'h0,    -1, 16'h0000, 0, -1);

        $display("[TB] leading-zero suppression");
        runFrame("t2_0056",   16'h0056, 4'h0,    1'b1, 1'b0, 1,  16'h0000, 4'h0,    -1, 16'h0000, 0, -1);

        $display("[TB] double load before boundary, latest wins");
        runFrame("t2_0000",   16'h0000, 4'h0,    1'b1, 1'b0, 3,  16'h1111, 4'hF,    8,  16'h2222, 0, -1);

        $display("[TB] load in the boundary cycle");
        runFrame("t3_2222",   16'h2222, 4'h0,    1'b1, 1'b0, 15, 16'h4321, 4'b1000, -1, 16'h0000, 0, -1);
        runFrame("t4_hold",   16'h2222, 4'h0,    1'b1, 1'b1, -1, 16'h0000, 4'h0,    -1, 16'h0000, 0, -1);
        runFrame("t4_4321",   16'h4321, 4'b1000, 1'b0, 1'b0, 1,  16'h78A9, 4'b0101, -1, 16'h0000, 0, -1);

        $display("[TB] invalid nibble and enable gap");
        runFrame("t5_78a9",   16'h78A9, 4'b0101, 1'b0, 1'b0, -1, 16'h0000, 4'h0,    -1, 16'h0000, 3, 12);

        $display("[TB] asynchronous reset mid-slot");
        applyStimulus(1'b1, 16'h5555, 4'hF, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'h5555, 4'hF, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t6 pre seg",     32'(seg),     32'h7B);
        checkOutput("t6 pre dig_en",  32'(dig_en),  32'h1);
        checkOutput("t6 pre dp",      32'(dp),      32'h1);
        checkOutput("t6 pre pending", 32'(pending), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6 async seg",        32'(seg),        32'd0);
        checkOutput("t6 async dp",         32'(dp),         32'd0);
        checkOutput("t6 async dig_en",     32'(dig_en),     32'd0);
        checkOutput("t6 async pending",    32'(pending),    32'd0);
        checkOutput("t6 async frame_tick", 32'(frame_tick), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        runFrame("t6_after",  16'h0000, 4'h0,    1'b0, 1'b0, -1, 16'h0000, 4'h0,    -1, 16'h0000, 0, -1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
